nn_weight_loader: RTL

//  Upstream configuration stage for the quantised QEC decoder network. Accepts weight and bias

---
 rtl/nn_weight_loader_if.sv | 13 +
 rtl/nn_weight_loader.sv | 104 ++++++++++
 2 files changed

// File: rtl/nn_weight_loader_if.sv
// Valid/ready word stream carrying weight and bias words into nn_weight_loader.
// The master drives valid/data/last; the slave answers with ready.
interface nn_weight_loader_if #(
  parameter int WEIGHT_BITS = 3
);
  logic                   valid;
  logic                   ready;
  logic [WEIGHT_BITS-1:0] data;
  logic                   last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/nn_weight_loader.sv
// Loads a framed stream of weight/bias words into shadow registers and commits them
// atomically to the active network parameter buses only when the frame is well formed.
module nn_weight_loader #(
  parameter int  N_INPUTS    = 4,
  parameter int  N_LAYER_1   = 2,
  parameter int  N_LAYER_2   = 2,
  parameter int  WEIGHT_BITS = 3,
  localparam int N_WEIGHTS   = N_INPUTS*N_LAYER_1 + N_LAYER_1*N_LAYER_2 + N_LAYER_2*2,
  localparam int N_BIAS      = N_LAYER_1 + N_LAYER_2 + 2,
  localparam int N_WORDS     = N_WEIGHTS + N_BIAS,
  localparam int CW          = $clog2(N_WORDS+1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  nn_weight_loader_if.slave                s,
  output logic [N_WEIGHTS*WEIGHT_BITS-1:0] weights_t,
  output logic [N_BIAS*WEIGHT_BITS-1:0]    bias_t,
  output logic                             loaded,
  output logic                             busy,
  output logic                             err,
  output logic [CW-1:0]                    word_cnt
);
  localparam int WB = WEIGHT_BITS;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, ERR} state_t;

  state_t                      state, next_state;
  logic [N_WEIGHTS*WB-1:0]     shadow_w;
  logic [N_BIAS*WB-1:0]        shadow_b;
  logic                        accept;
  logic                        clear;
  logic                        last_word;
  logic                        set_err;

  assign s.ready   = (state == LOAD);
  // A start in LOAD restarts the frame, so a word offered in that same cycle is dropped.
  assign accept    = s.valid && s.ready && !start;
  assign clear     = start && (state != COMMIT);
  assign last_word = (word_cnt == CW'(N_WORDS-1));

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    next_state = state;
    set_err    = 1'b0;
    case (state)
      IDLE:   if (start) next_state = LOAD;
      LOAD: begin
        if (accept) begin
          if (last_word && s.last) begin
            next_state = COMMIT;
          end else if (last_word || s.last) begin
            next_state = ERR;
            set_err    = 1'b1;
          end
        end
      end
      COMMIT: next_state = IDLE;
      ERR:    if (start) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shadow registers are reset too, so nothing stale can ever reach the active buses.
      state     <= IDLE;
      busy      <= 1'b0;
      err       <= 1'b0;
      loaded    <= 1'b0;
      word_cnt  <= '0;
      shadow_w  <= '0;
      shadow_b  <= '0;
      weights_t <= '0;
      bias_t    <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state == LOAD) || (next_state == COMMIT);

      if (clear) begin
        word_cnt <= '0;
        err      <= 1'b0;
        shadow_w <= '0;
        shadow_b <= '0;
      end else if (accept) begin
        word_cnt <= word_cnt + 1'b1;
        for (int k = 0; k < N_WEIGHTS; k++)
          if (word_cnt == CW'(k)) shadow_w[k*WB +: WB] <= s.data;
        for (int k = 0; k < N_BIAS; k++)
          if (word_cnt == CW'(N_WEIGHTS+k)) shadow_b[k*WB +: WB] <= s.data;
      end

      if (set_err) err <= 1'b1;

      // The only edge on which the active parameter set changes.
      if (state == COMMIT) begin
        weights_t <= shadow_w;
        bias_t    <= shadow_b;
        loaded    <= 1'b1;
      end
    end
  end
endmodule
